// File: rtl/pipe_pkg.sv
// Shared pipeline types: ROB index, exception vector and packed stage payloads.
// The default stage payload width is $bits(exmem_payload_t) = 72.
package pipe_pkg;
  localparam int PIPE_ROB_IDX_W = 4;
  localparam int EXC_VEC_W      = 3;

  typedef logic [PIPE_ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [EXC_VEC_W-1:0]      exc_vec_t;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    exc_vec_t    exc;
  } exmem_payload_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [31:0] pc;
    logic [4:0]  rd;
    exc_vec_t    exc;
  } memwb_payload_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid holder for pipe_stage_reg; built only when PIPE_STAGE_SKID_EN is defined.
`ifdef PIPE_STAGE_SKID_EN
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 76
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush_i)     valid_q <= 1'b0;
      else if (push_i) valid_q <= 1'b1;
      else if (pop_i)  valid_q <= 1'b0;
      if (push_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline-stage register with flush, d-cache freeze and stall counter.
// Define PIPE_STAGE_SKID_EN for a registered in_ready backed by a one-entry skid buffer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W    = $bits(exmem_payload_t),
  parameter int ROB_IDX_W = PIPE_ROB_IDX_W,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_payload,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic                 in_flush,
  input  logic                 in_stall,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_payload,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  output logic [CNT_W-1:0]     out_stall_cycles
);
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                 valid_q, valid_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [ROB_IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 accept, pop, blocked;

  assign pop     = valid_q && out_ready && !in_stall;
  assign accept  = in_valid && in_ready;
  assign blocked = (valid_q && (!out_ready || in_stall)) || (in_valid && !in_ready);

`ifdef PIPE_STAGE_SKID_EN
  logic                        skid_valid, skid_push, skid_pop;
  logic [DATA_W+ROB_IDX_W-1:0] skid_bus;

  // Skid fills only when main is occupied and not draining this cycle.
  assign in_ready  = !skid_valid;
  assign skid_push = accept && valid_q && !pop && !in_flush;
  assign skid_pop  = pop && skid_valid;

  pipe_skid_buf #(.W(DATA_W + ROB_IDX_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .flush_i (in_flush),
    .data_i  ({in_payload, in_rob_idx}),
    .valid_o (skid_valid),
    .data_o  (skid_bus)
  );

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    if (pop) begin
      if (skid_valid) begin
        valid_d = 1'b1;
        data_d  = skid_bus[DATA_W+ROB_IDX_W-1:ROB_IDX_W];
        idx_d   = skid_bus[ROB_IDX_W-1:0];
      end else if (accept) begin
        valid_d = 1'b1;
        data_d  = in_payload;
        idx_d   = in_rob_idx;
      end else begin
        valid_d = 1'b0;
      end
    end else if (!valid_q && accept) begin
      valid_d = 1'b1;
      data_d  = in_payload;
      idx_d   = in_rob_idx;
    end
    if (in_flush) valid_d = 1'b0;
  end
`else
  assign in_ready = !in_stall && (!valid_q || out_ready);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = in_payload;
      idx_d   = in_rob_idx;
    end else if (pop) begin
      valid_d = 1'b0;
    end
    if (in_flush) valid_d = 1'b0;
  end
`endif

  // Stage register and stall counter; flush leaves the counter untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      if (blocked) cnt_q <= sat_inc(cnt_q);
    end
  end

  assign out_valid        = valid_q;
  assign out_payload      = data_q;
  assign out_rob_idx      = idx_q;
  assign out_stall_cycles = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed plus randomized bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_flush, in_stall, out_ready;
  logic [71:0] in_payload;
  logic [3:0]  in_rob_idx;
  logic        in_ready, out_valid, s_in_ready, s_out_valid;
  logic [71:0] out_payload, s_out_payload;
  logic [3:0]  out_rob_idx, s_out_rob_idx, s_cnt;
  logic [15:0] out_stall_cycles;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload), .in_rob_idx(in_rob_idx), .in_flush(in_flush),
    .in_stall(in_stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_payload(out_payload), .out_rob_idx(out_rob_idx),
    .out_stall_cycles(out_stall_cycles)
  );

  pipe_stage_reg #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_payload(in_payload), .in_rob_idx(in_rob_idx), .in_flush(in_flush),
    .in_stall(in_stall), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_payload(s_out_payload), .out_rob_idx(s_out_rob_idx),
    .out_stall_cycles(s_cnt)
  );

  typedef struct packed {
    logic [71:0] d;
    logic [3:0]  i;
  } ent_t;

  ent_t        q[$];
  int unsigned m_cnt  = 0;
  int unsigned m_cnt4 = 0;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < 2;
`else
    return !in_stall && (q.size() == 0 || out_ready);
`endif
  endfunction

  // One clock: compare outputs at negedge, advance the model at posedge.
  task automatic cyc();
    logic exp_rdy, exp_vld, blk, pop, acc;
    ent_t e;
    @(negedge clk);
    exp_rdy = model_ready();
    exp_vld = q.size() > 0;
    chk("in_ready", 72'(in_ready), 72'(exp_rdy));
    chk("out_valid", 72'(out_valid), 72'(exp_vld));
    chk("stall_cnt", 72'(out_stall_cycles), 72'(m_cnt));
    chk("sat_in_ready", 72'(s_in_ready), 72'(exp_rdy));
    chk("sat_out_valid", 72'(s_out_valid), 72'(exp_vld));
    chk("sat_cnt", 72'(s_cnt), 72'(m_cnt4));
    if (exp_vld) begin
      chk("out_payload", out_payload, q[0].d);
      chk("out_rob_idx", 72'(out_rob_idx), 72'(q[0].i));
      chk("sat_payload", s_out_payload, q[0].d);
    end
    @(posedge clk);
    if (!reset) begin
      q.delete();
      m_cnt  = 0;
      m_cnt4 = 0;
    end else begin
      blk = (exp_vld && (!out_ready || in_stall)) || (in_valid && !exp_rdy);
      if (blk && m_cnt < 65535) m_cnt++;
      if (blk && m_cnt4 < 15) m_cnt4++;
      if (in_flush) q.delete();
      else begin
        pop = exp_vld && out_ready && !in_stall;
        acc = in_valid && exp_rdy;
        if (pop) void'(q.pop_front());
        if (acc) begin
          e.d = in_payload;
          e.i = in_rob_idx;
          q.push_back(e);
        end
      end
    end
    #1;
  endtask

  int unsigned c0;

  initial begin
    reset = 1'b0; in_valid = 1'b1; in_payload = 72'h99; in_rob_idx = 4'h3;
    in_flush = 1'b0; in_stall = 1'b0; out_ready = 1'b1;

    // Reset held with a valid input offered.
    repeat (2) cyc();
    chk("rst_valid", 72'(out_valid), 72'd0);
    chk("rst_payload", out_payload, 72'd0);
    chk("rst_cnt", 72'(out_stall_cycles), 72'd0);
    reset = 1'b1;

    // Streaming 1..4 with no bubbles.
    for (int p = 1; p <= 4; p++) begin
      in_valid = 1'b1; in_payload = 72'(p); in_rob_idx = 4'(p);
      cyc();
      chk("stream_out", out_payload, 72'(p));
    end
    in_valid = 1'b0;
    cyc();

    // Backpressure on 0xA5 with 0x5A offered behind it.
    in_valid = 1'b1; in_payload = 72'hA5; in_rob_idx = 4'h5;
    cyc();
    out_ready = 1'b0; in_payload = 72'h5A; in_rob_idx = 4'h6;
    c0 = 32'(out_stall_cycles);
    repeat (3) cyc();
    chk("bp_hold", out_payload, 72'hA5);
    chk("bp_cnt_delta", 72'(32'(out_stall_cycles) - c0), 72'd3);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("bp_next", out_payload, 72'h5A);
    cyc();

    // Global stall with downstream ready.
    in_valid = 1'b1; in_payload = 72'hB6; in_rob_idx = 4'h7; out_ready = 1'b0;
    cyc();
    in_valid = 1'b0; in_stall = 1'b1; out_ready = 1'b1;
    c0 = 32'(out_stall_cycles);
    repeat (5) cyc();
    chk("stall_hold", out_payload, 72'hB6);
    chk("stall_cnt_delta", 72'(32'(out_stall_cycles) - c0), 72'd5);
    in_stall = 1'b0;

    // Flush in the same cycle as an offered 0x77.
    in_flush = 1'b1; in_valid = 1'b1; in_payload = 72'h77; in_rob_idx = 4'h8;
    cyc();
    in_flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 72'(out_valid), 72'd0);
    repeat (3) cyc();

    // Saturation of the 4-bit counter.
    in_valid = 1'b1; in_payload = 72'hC3; in_rob_idx = 4'h9; out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    repeat (20) cyc();
    chk("sat_15", 72'(s_cnt), 72'd15);
    out_ready = 1'b1;
    repeat (2) cyc();

    // Randomized traffic with occasional flush, stall and reset.
    for (int n = 0; n < 400; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_payload = {8'($urandom()), $urandom(), $urandom()};
      in_rob_idx = 4'($urandom());
      out_ready  = ($urandom_range(0, 9) < 7);
      in_stall   = ($urandom_range(0, 9) == 0);
      in_flush   = ($urandom_range(0, 19) == 0);
      reset      = ($urandom_range(0, 49) != 0);
      cyc();
    end
    reset = 1'b1; in_valid = 1'b0; in_flush = 1'b0; in_stall = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
